gram_rr_arbiter: RTL and testbench

//  Shares the single graphics-RAM port among one display fetch requester and two

---
 rtl/gram_rr_arbiter.sv | 143 ++++++++++++++
 tb/tb_gram_rr_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gram_rr_arbiter.sv
// Graphics-RAM port arbiter.
// One display-fetch requester and two draw requesters share a single BRAM port.
// Fetch has priority, but its run of consecutive grants is bounded so that a
// waiting drawer still gets in. The two drawers are served round-robin.
// The granted request is registered onto the BRAM port. Read data is broadcast
// with a one-hot tag that names the requester the data belongs to.
//
// Handshake: each requester raises *_rts_in (valid) and keeps addr/wrdata/op
// stable. The arbiter answers with *_rtr_out (ready). A transfer happens on a
// clock edge where both are high. At most one rtr_out is high in any cycle, and
// rtr_out is only raised for a requester whose rts_in is high. A requester that
// is not granted keeps its request asserted and unchanged until it is granted.
module gram_rr_arbiter #(
   parameter int ADDR_W        = 17,
   parameter int DATA_W        = 32,
   parameter int WBEN_W        = 4,
   parameter int RD_LATENCY    = 1,
   parameter int MAX_FETCH_RUN = 4
) (
   input  logic              clk,
   input  logic              rst_,
   input  logic              hold,
   input  logic [ADDR_W-1:0] fetch_addr,
   input  logic              fetch_rts_in,
   output logic              fetch_rtr_out,
   input  logic [ADDR_W-1:0] drw0_addr,
   input  logic [DATA_W-1:0] drw0_wrdata,
   input  logic [WBEN_W-1:0] drw0_op,
   input  logic              drw0_rts_in,
   output logic              drw0_rtr_out,
   input  logic [ADDR_W-1:0] drw1_addr,
   input  logic [DATA_W-1:0] drw1_wrdata,
   input  logic [WBEN_W-1:0] drw1_op,
   input  logic              drw1_rts_in,
   output logic              drw1_rtr_out,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data_out,
   output logic [WBEN_W-1:0] wben,
   input  logic [DATA_W-1:0] mem_data_in,
   output logic [DATA_W-1:0] bcast_data,
   output logic [2:0]        bcast_xfc_out,
   output logic              busy
);

   localparam int RUN_W = $clog2(MAX_FETCH_RUN + 1);
   localparam int TAG_D = RD_LATENCY + 1;

   // rr_ptr: 0 = drawer 0 has the round-robin turn, 1 = drawer 1
   logic                        rr_ptr_q, rr_ptr_d;
   logic [RUN_W-1:0]            run_cnt_q, run_cnt_d;
   logic [ADDR_W-1:0]           mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]           mem_data_q, mem_data_d;
   logic [WBEN_W-1:0]           wben_q, wben_d;
   // tag_q[0] is the newest entry; the oldest one is the read-return tag
   logic [TAG_D-1:0][2:0]       tag_q, tag_d;

   logic gnt_f, gnt_d0, gnt_d1;
   logic any_drw, any_gnt;
   logic [2:0] rd_tag;

   // Grant selection: fetch first while its run is short, then round-robin drawers
   always_comb begin
      gnt_f   = 1'b0;
      gnt_d0  = 1'b0;
      gnt_d1  = 1'b0;
      any_drw = drw0_rts_in | drw1_rts_in;
      if (rst_ && !hold) begin
         if (fetch_rts_in && ((run_cnt_q < RUN_W'(MAX_FETCH_RUN)) || !any_drw)) begin
            gnt_f = 1'b1;
         end else if (!rr_ptr_q) begin
            if (drw0_rts_in)      gnt_d0 = 1'b1;
            else if (drw1_rts_in) gnt_d1 = 1'b1;
         end else begin
            if (drw1_rts_in)      gnt_d1 = 1'b1;
            else if (drw0_rts_in) gnt_d0 = 1'b1;
         end
      end
   end

   // Next-state: fetch run length, round-robin turn, BRAM request, tag pipeline
   always_comb begin
      any_gnt    = gnt_f | gnt_d0 | gnt_d1;
      run_cnt_d  = '0;
      rr_ptr_d   = rr_ptr_q;
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
      wben_d     = '0;
      rd_tag     = 3'b000;
      if (gnt_f) begin
         // saturate so a long fetch burst keeps the drawers' claim alive
         run_cnt_d  = (run_cnt_q == RUN_W'(MAX_FETCH_RUN)) ? run_cnt_q
                                                            : run_cnt_q + RUN_W'(1);
         mem_addr_d = fetch_addr;
         rd_tag     = 3'b001;
      end else if (gnt_d0) begin
         rr_ptr_d   = 1'b1;
         mem_addr_d = drw0_addr;
         mem_data_d = drw0_wrdata;
         wben_d     = drw0_op;
         rd_tag     = (drw0_op == '0) ? 3'b010 : 3'b000;
      end else if (gnt_d1) begin
         rr_ptr_d   = 1'b0;
         mem_addr_d = drw1_addr;
         mem_data_d = drw1_wrdata;
         wben_d     = drw1_op;
         rd_tag     = (drw1_op == '0) ? 3'b100 : 3'b000;
      end
      tag_d = {tag_q[TAG_D-2:0], rd_tag};
   end

   // State registers; reset also drops any reads still in flight
   always_ff @(posedge clk) begin
      if (!rst_) begin
         rr_ptr_q   <= 1'b0;
         run_cnt_q  <= '0;
         mem_addr_q <= '0;
         mem_data_q <= '0;
         wben_q     <= '0;
         tag_q      <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         run_cnt_q  <= run_cnt_d;
         mem_addr_q <= mem_addr_d;
         mem_data_q <= mem_data_d;
         wben_q     <= wben_d;
         tag_q      <= tag_d;
      end
   end

   // Outputs: grants, registered BRAM port, read-return broadcast
   always_comb begin
      fetch_rtr_out = gnt_f;
      drw0_rtr_out  = gnt_d0;
      drw1_rtr_out  = gnt_d1;
      mem_addr      = mem_addr_q;
      mem_data_out  = mem_data_q;
      wben          = wben_q;
      bcast_data    = mem_data_in;
      bcast_xfc_out = tag_q[TAG_D-1];
      busy          = |tag_q;
   end

endmodule

// File: tb/tb_gram_rr_arbiter.sv
// Directed testbench for gram_rr_arbiter with a one-cycle-latency BRAM model.
// Inputs are driven 1 ns after the rising edge; outputs are checked on the
// falling edge of the same cycle.
module tb_gram_rr_arbiter;

   logic        clk = 1'b0;
   logic        rst_;
   logic        hold;
   logic [16:0] fetch_addr;
   logic        fetch_rts_in;
   logic        fetch_rtr_out;
   logic [16:0] drw0_addr;
   logic [31:0] drw0_wrdata;
   logic [3:0]  drw0_op;
   logic        drw0_rts_in;
   logic        drw0_rtr_out;
   logic [16:0] drw1_addr;
   logic [31:0] drw1_wrdata;
   logic [3:0]  drw1_op;
   logic        drw1_rts_in;
   logic        drw1_rtr_out;
   logic [16:0] mem_addr;
   logic [31:0] mem_data_out;
   logic [3:0]  wben;
   logic [31:0] mem_data_in;
   logic [31:0] bcast_data;
   logic [2:0]  bcast_xfc_out;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   logic [31:0] bram [0:131071];

   always #5 clk = ~clk;

   gram_rr_arbiter dut (
      .clk(clk), .rst_(rst_), .hold(hold),
      .fetch_addr(fetch_addr), .fetch_rts_in(fetch_rts_in), .fetch_rtr_out(fetch_rtr_out),
      .drw0_addr(drw0_addr), .drw0_wrdata(drw0_wrdata), .drw0_op(drw0_op),
      .drw0_rts_in(drw0_rts_in), .drw0_rtr_out(drw0_rtr_out),
      .drw1_addr(drw1_addr), .drw1_wrdata(drw1_wrdata), .drw1_op(drw1_op),
      .drw1_rts_in(drw1_rts_in), .drw1_rtr_out(drw1_rtr_out),
      .mem_addr(mem_addr), .mem_data_out(mem_data_out), .wben(wben),
      .mem_data_in(mem_data_in), .bcast_data(bcast_data),
      .bcast_xfc_out(bcast_xfc_out), .busy(busy)
   );

   // BRAM model: byte-enabled write, registered read (latency 1)
   always @(posedge clk) begin
      for (int b = 0; b < 4; b++)
         if (wben[b]) bram[mem_addr][b*8 +: 8] <= mem_data_out[b*8 +: 8];
      mem_data_in <= bram[mem_addr];
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      hold = 1'b0;
      fetch_rts_in = 1'b0;
      drw0_rts_in = 1'b0;
      drw1_rts_in = 1'b0;
      drw0_op = 4'h0;
      drw1_op = 4'h0;
   endtask

   task automatic test_reset();
      rst_ = 1'b0;
      idle_inputs();
      fetch_addr = 17'h0; drw0_addr = 17'h0; drw1_addr = 17'h0;
      drw0_wrdata = 32'h0; drw1_wrdata = 32'h0;
      cyc(); cyc();
      // requests raised during reset must not be granted
      fetch_rts_in = 1'b1; drw0_rts_in = 1'b1; drw1_rts_in = 1'b1;
      @(negedge clk);
      checks++;
      if ({drw1_rtr_out, drw0_rtr_out, fetch_rtr_out} !== 3'b000) begin
         failures++; $display("FAIL reset_grant got=%b exp=000", {drw1_rtr_out, drw0_rtr_out, fetch_rtr_out});
      end
      checks++;
      if (mem_addr !== 17'h0 || mem_data_out !== 32'h0 || wben !== 4'h0) begin
         failures++; $display("FAIL reset_port got=%h/%h/%h exp=0/0/0", mem_addr, mem_data_out, wben);
      end
      checks++;
      if (bcast_xfc_out !== 3'b000 || busy !== 1'b0) begin
         failures++; $display("FAIL reset_tag got=%b/%b exp=000/0", bcast_xfc_out, busy);
      end
      cyc();
      idle_inputs();
      rst_ = 1'b1;
      cyc();
   endtask

   task automatic test_fetch_read();
      bram[17'h00010] = 32'hDEADBEEF;
      fetch_addr = 17'h00010; fetch_rts_in = 1'b1;
      @(negedge clk);
      checks++;
      if ({drw1_rtr_out, drw0_rtr_out, fetch_rtr_out} !== 3'b001) begin
         failures++; $display("FAIL fetch_grant got=%b exp=001", {drw1_rtr_out, drw0_rtr_out, fetch_rtr_out});
      end
      cyc();
      fetch_rts_in = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_addr !== 17'h00010 || wben !== 4'h0 || busy !== 1'b1 || bcast_xfc_out !== 3'b000) begin
         failures++; $display("FAIL fetch_issue got=%h/%h/%b/%b exp=00010/0/1/000", mem_addr, wben, busy, bcast_xfc_out);
      end
      cyc();
      @(negedge clk);
      checks++;
      if (bcast_xfc_out !== 3'b001 || bcast_data !== 32'hDEADBEEF) begin
         failures++; $display("FAIL fetch_return got=%b/%h exp=001/deadbeef", bcast_xfc_out, bcast_data);
      end
      cyc();
      @(negedge clk);
      checks++;
      if (bcast_xfc_out !== 3'b000 || busy !== 1'b0) begin
         failures++; $display("FAIL fetch_done got=%b/%b exp=000/0", bcast_xfc_out, busy);
      end
      cyc();
   endtask

   task automatic test_back_to_back();
      logic [31:0] vals [3];
      vals[0] = 32'h11111111; vals[1] = 32'h22222222; vals[2] = 32'h33333333;
      for (int i = 0; i < 3; i++) bram[17'h00020 + 17'(i)] = vals[i];
      for (int i = 0; i < 5; i++) begin
         fetch_rts_in = (i < 3);
         fetch_addr = 17'h00020 + 17'(i);
         @(negedge clk);
         if (i < 3) begin
            checks++;
            if (fetch_rtr_out !== 1'b1) begin
               failures++; $display("FAIL b2b_grant%0d got=%b exp=1", i, fetch_rtr_out);
            end
         end
         if (i >= 2) begin
            checks++;
            if (bcast_xfc_out !== 3'b001 || bcast_data !== vals[i-2]) begin
               failures++; $display("FAIL b2b_return%0d got=%b/%h exp=001/%h", i-2, bcast_xfc_out, bcast_data, vals[i-2]);
            end
         end
         cyc();
      end
      fetch_rts_in = 1'b0;
      cyc();
   endtask

   task automatic test_drw_rr();
      logic [2:0] exp_g [4];
      exp_g[0] = 3'b010; exp_g[1] = 3'b100; exp_g[2] = 3'b010; exp_g[3] = 3'b100;
      rst_ = 1'b0;
      cyc();
      rst_ = 1'b1;
      drw0_addr = 17'h00100; drw1_addr = 17'h00200;
      for (int i = 0; i < 6; i++) begin
         drw0_rts_in = (i < 4);
         drw1_rts_in = (i < 4);
         @(negedge clk);
         if (i < 4) begin
            checks++;
            if ({drw1_rtr_out, drw0_rtr_out, fetch_rtr_out} !== exp_g[i]) begin
               failures++; $display("FAIL rr_grant%0d got=%b exp=%b", i, {drw1_rtr_out, drw0_rtr_out, fetch_rtr_out}, exp_g[i]);
            end
         end
         if (i >= 2) begin
            checks++;
            if (bcast_xfc_out !== exp_g[i-2]) begin
               failures++; $display("FAIL rr_tag%0d got=%b exp=%b", i-2, bcast_xfc_out, exp_g[i-2]);
            end
         end
         cyc();
      end
   endtask

   task automatic test_fetch_run();
      logic [2:0] exp;
      fetch_addr = 17'h00040; drw0_addr = 17'h00050;
      fetch_rts_in = 1'b1; drw0_rts_in = 1'b1;
      for (int i = 0; i < 10; i++) begin
         exp = (i == 4 || i == 9) ? 3'b010 : 3'b001;
         @(negedge clk);
         checks++;
         if ({drw1_rtr_out, drw0_rtr_out, fetch_rtr_out} !== exp) begin
            failures++; $display("FAIL run_grant%0d got=%b exp=%b", i, {drw1_rtr_out, drw0_rtr_out, fetch_rtr_out}, exp);
         end
         cyc();
      end
      fetch_rts_in = 1'b0; drw0_rts_in = 1'b0;
      cyc(); cyc(); cyc();
   endtask

   task automatic test_write();
      bram[17'h1FFFF] = 32'hAAAAAAAA;
      drw1_addr = 17'h1FFFF; drw1_op = 4'b0011; drw1_wrdata = 32'h12345678; drw1_rts_in = 1'b1;
      @(negedge clk);
      checks++;
      if ({drw1_rtr_out, drw0_rtr_out, fetch_rtr_out} !== 3'b100) begin
         failures++; $display("FAIL wr_grant got=%b exp=100", {drw1_rtr_out, drw0_rtr_out, fetch_rtr_out});
      end
      cyc();
      drw1_rts_in = 1'b0; drw1_op = 4'h0;
      @(negedge clk);
      checks++;
      if (wben !== 4'b0011 || mem_addr !== 17'h1FFFF || mem_data_out !== 32'h12345678) begin
         failures++; $display("FAIL wr_issue got=%h/%h/%h exp=3/1ffff/12345678", wben, mem_addr, mem_data_out);
      end
      cyc();
      @(negedge clk);
      checks++;
      if (wben !== 4'h0 || bram[17'h1FFFF] !== 32'hAAAA5678 || bcast_xfc_out !== 3'b000) begin
         failures++; $display("FAIL wr_result got=%h/%h/%b exp=0/aaaa5678/000", wben, bram[17'h1FFFF], bcast_xfc_out);
      end
      cyc();
      @(negedge clk);
      checks++;
      if (bcast_xfc_out !== 3'b000 || busy !== 1'b0) begin
         failures++; $display("FAIL wr_notag got=%b/%b exp=000/0", bcast_xfc_out, busy);
      end
      cyc();
   endtask

   task automatic test_hold();
      drw0_addr = 17'h00300; drw0_op = 4'h0; drw0_rts_in = 1'b1;
      @(negedge clk);
      checks++;
      if ({drw1_rtr_out, drw0_rtr_out, fetch_rtr_out} !== 3'b010) begin
         failures++; $display("FAIL hold_first got=%b exp=010", {drw1_rtr_out, drw0_rtr_out, fetch_rtr_out});
      end
      cyc();
      hold = 1'b1; fetch_rts_in = 1'b1; drw1_rts_in = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         checks++;
         if ({drw1_rtr_out, drw0_rtr_out, fetch_rtr_out} !== 3'b000 || busy !== (i < 3)) begin
            failures++; $display("FAIL hold_t%0d got=%b/%b exp=000/%b", i, {drw1_rtr_out, drw0_rtr_out, fetch_rtr_out}, busy, (i < 3));
         end
         checks++;
         if (bcast_xfc_out !== ((i == 2) ? 3'b010 : 3'b000)) begin
            failures++; $display("FAIL hold_tag_t%0d got=%b exp=%b", i, bcast_xfc_out, ((i == 2) ? 3'b010 : 3'b000));
         end
         cyc();
      end
      idle_inputs();
      cyc();
   endtask

   task automatic test_reset_drop();
      drw1_addr = 17'h00ABC; drw1_op = 4'h0; drw1_rts_in = 1'b1;
      @(negedge clk);
      checks++;
      if (drw1_rtr_out !== 1'b1) begin
         failures++; $display("FAIL drop_grant got=%b exp=1", drw1_rtr_out);
      end
      cyc();
      drw1_rts_in = 1'b0; rst_ = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_addr !== 17'h00ABC) begin
         failures++; $display("FAIL drop_issue got=%h exp=00abc", mem_addr);
      end
      cyc();
      rst_ = 1'b1;
      @(negedge clk);
      checks++;
      if (mem_addr !== 17'h0 || mem_data_out !== 32'h0 || wben !== 4'h0 || bcast_xfc_out !== 3'b000 || busy !== 1'b0) begin
         failures++; $display("FAIL drop_clear got=%h/%h/%h/%b/%b exp=0/0/0/000/0", mem_addr, mem_data_out, wben, bcast_xfc_out, busy);
      end
      cyc();
      @(negedge clk);
      checks++;
      if (bcast_xfc_out !== 3'b000) begin
         failures++; $display("FAIL drop_notag got=%b exp=000", bcast_xfc_out);
      end
      cyc();
   endtask

   initial begin
      #1;
      test_reset();
      test_fetch_read();
      test_back_to_back();
      test_drw_rr();
      test_fetch_run();
      test_write();
      test_hold();
      test_reset_drop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
